// File: rtl/wb_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: pipeline writeback,
// memory response channel, register-file write port and pending-entry status.
interface wb_arbiter_if;
  logic        p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        p_stall;
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        pend_valid;
  logic [4:0]  pend_rd;

  modport slave (
    input  p_valid, p_rd, p_data, m_valid, m_rd, m_data,
    output p_stall, m_ready, rf_we, rf_rd, rf_data, pend_valid, pend_rd
  );

  modport master (
    output p_valid, p_rd, p_data, m_valid, m_rd, m_data,
    input  p_stall, m_ready, rf_we, rf_rd, rf_data, pend_valid, pend_rd
  );
endinterface

// File: rtl/wb_arbiter.sv
// Shares one register-file write port between the pipeline writeback stage and
// a one-entry memory-response buffer, with a bounded starvation counter.
module wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic        buf_full;
  logic [4:0]  buf_rd;
  logic [31:0] buf_data;
  logic [3:0]  starve_cnt;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  logic pv;
  logic grant_buf;
  logic grant_p;
  logic m_ready;
  logic accept;

  // Reset gates the grants so nothing is written and inputs are simply dropped.
  always_comb begin
    pv        = bus.p_valid && (bus.p_rd != 5'd0);
    grant_buf = !rst && buf_full && (!pv || (starve_cnt < STARVE_LIM));
    grant_p   = !rst && pv && !grant_buf;
    m_ready   = rst || !buf_full || grant_buf;
    accept    = bus.m_valid && m_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_rd      <= 5'd0;
      rf_data    <= 32'd0;
      buf_full   <= 1'b0;
      buf_rd     <= 5'd0;
      buf_data   <= 32'd0;
      starve_cnt <= 4'd0;
    end else begin
      rf_we <= grant_buf || grant_p;
      if (grant_buf) begin
        rf_rd   <= buf_rd;
        rf_data <= buf_data;
      end else if (grant_p) begin
        rf_rd   <= bus.p_rd;
        rf_data <= bus.p_data;
      end

      // A draining buffer may be refilled on the same edge.
      if (accept && (bus.m_rd != 5'd0)) begin
        buf_full <= 1'b1;
        buf_rd   <= bus.m_rd;
        buf_data <= bus.m_data;
      end else if (grant_buf) begin
        buf_full <= 1'b0;
      end

      if (grant_buf && pv) starve_cnt <= starve_cnt + 4'd1;
      else                 starve_cnt <= 4'd0;
    end
  end

  assign bus.p_stall    = pv && grant_buf;
  assign bus.m_ready    = m_ready;
  assign bus.rf_we      = rf_we;
  assign bus.rf_rd      = rf_rd;
  assign bus.rf_data    = rf_data;
  assign bus.pend_valid = buf_full;
  assign bus.pend_rd    = buf_rd;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter: reset, pipeline-only, contention,
// drain/refill, rd 0 handling, starvation pattern and reset discard.
module tb_wb_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pvl, input logic [4:0] prd, input logic [31:0] pdat,
                       input logic mvl, input logic [4:0] mrd, input logic [31:0] mdat);
    bus.p_valid = pvl;
    bus.p_rd    = prd;
    bus.p_data  = pdat;
    bus.m_valid = mvl;
    bus.m_rd    = mrd;
    bus.m_data  = mdat;
  endtask

  // Starvation pattern with STARVE_MAX=4, pipeline rd 4 held, a response always offered.
  int exp_rd [11] = '{4, 16, 17, 18, 19, 4, 20, 21, 22, 23, 4};
  bit exp_mr [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit exp_st [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int idx;
    n_vec = 0;
    n_err = 0;

    // Reset: inputs offered during reset are dropped
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'h5555, 1'b1, 5'd12, 32'hC0C0);
    #1;
    chk("rst_m_ready", 32'(bus.m_ready), 32'd1);
    chk("rst_p_stall", 32'(bus.p_stall), 32'd0);
    tick();
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
    chk("rst_rf_data", bus.rf_data, 32'd0);
    chk("rst_pend_valid", 32'(bus.pend_valid), 32'd0);
    chk("rst_pend_rd", 32'(bus.pend_rd), 32'd0);

    // Pipeline only
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    #1;
    chk("p_only_stall", 32'(bus.p_stall), 32'd0);
    tick();
    chk("p_only_we", 32'(bus.rf_we), 32'd1);
    chk("p_only_rd", 32'(bus.rf_rd), 32'd5);
    chk("p_only_data", bus.rf_data, 32'h1234);

    // No grant: write port holds
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("idle_we", 32'(bus.rf_we), 32'd0);
    chk("idle_rd_hold", 32'(bus.rf_rd), 32'd5);
    chk("idle_data_hold", bus.rf_data, 32'h1234);

    // Contention: buffer rd 7 vs pipeline rd 3
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
    #1;
    chk("load7_m_ready", 32'(bus.m_ready), 32'd1);
    tick();
    chk("load7_pend_valid", 32'(bus.pend_valid), 32'd1);
    chk("load7_pend_rd", 32'(bus.pend_rd), 32'd7);
    chk("load7_we", 32'(bus.rf_we), 32'd0);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    #1;
    chk("cont_stall", 32'(bus.p_stall), 32'd1);
    tick();
    chk("cont_we1", 32'(bus.rf_we), 32'd1);
    chk("cont_rd1", 32'(bus.rf_rd), 32'd7);
    chk("cont_data1", bus.rf_data, 32'hAA);
    chk("cont_pend_valid", 32'(bus.pend_valid), 32'd0);
    chk("cont_stall2", 32'(bus.p_stall), 32'd0);
    tick();
    chk("cont_we2", 32'(bus.rf_we), 32'd1);
    chk("cont_rd2", 32'(bus.rf_rd), 32'd3);
    chk("cont_data2", bus.rf_data, 32'h33);

    // Drain plus refill
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    #1;
    chk("refill_m_ready", 32'(bus.m_ready), 32'd1);
    tick();
    chk("refill_we", 32'(bus.rf_we), 32'd1);
    chk("refill_rd", 32'(bus.rf_rd), 32'd8);
    chk("refill_data", bus.rf_data, 32'h88);
    chk("refill_pend_valid", 32'(bus.pend_valid), 32'd1);
    chk("refill_pend_rd", 32'(bus.pend_rd), 32'd9);

    // Drain rd 9, then rd 0 on both sides
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("drain9_rd", 32'(bus.rf_rd), 32'd9);
    chk("drain9_pend_valid", 32'(bus.pend_valid), 32'd0);
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    #1;
    chk("rd0_stall", 32'(bus.p_stall), 32'd0);
    chk("rd0_m_ready", 32'(bus.m_ready), 32'd1);
    tick();
    chk("rd0_we", 32'(bus.rf_we), 32'd0);
    chk("rd0_pend_valid", 32'(bus.pend_valid), 32'd0);

    // Starvation: 4 buffer writes then 1 pipeline write, repeating
    idx = 0;
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, 5'd4, 32'h44, 1'b1, 5'(16 + idx), 32'h1000 + 32'(16 + idx));
      #1;
      chk($sformatf("starve_m_ready_%0d", k), 32'(bus.m_ready), 32'(exp_mr[k]));
      chk($sformatf("starve_stall_%0d", k), 32'(bus.p_stall), 32'(exp_st[k]));
      tick();
      chk($sformatf("starve_we_%0d", k), 32'(bus.rf_we), 32'd1);
      chk($sformatf("starve_rd_%0d", k), 32'(bus.rf_rd), 32'(exp_rd[k]));
      chk($sformatf("starve_data_%0d", k), bus.rf_data,
          (exp_rd[k] == 4) ? 32'h44 : 32'h1000 + 32'(exp_rd[k]));
      if (exp_mr[k]) idx++;
    end

    // Buffer still holds rd 24; drain it, then load rd 12 and reset
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("post_starve_rd", 32'(bus.rf_rd), 32'd24);
    chk("post_starve_data", bus.rf_data, 32'h1018);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC12);
    tick();
    chk("load12_pend_valid", 32'(bus.pend_valid), 32'd1);
    chk("load12_pend_rd", 32'(bus.pend_rd), 32'd12);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    tick();
    chk("rst12_pend_valid", 32'(bus.pend_valid), 32'd0);
    chk("rst12_we", 32'(bus.rf_we), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst12_after_we_%0d", k), 32'(bus.rf_we), 32'd0);
      chk($sformatf("rst12_after_pend_%0d", k), 32'(bus.pend_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive buffer grants while the pipeline is waiting; legal range 1-15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 p_valid  input  1  pipeline writeback request; p_data is the writeback-mux result.
REQ-005 p_rd  input  5  pipeline destination register index.
REQ-006 p_data  input  32  pipeline writeback data.
REQ-007 p_stall  output  1  combinational; holds the pipeline writeback stage for this cycle.
REQ-008 m_valid  input  1  memory/load-unit response valid.
REQ-009 m_rd  input  5  memory response destination register index.
REQ-010 m_data  input  32  memory response data.
REQ-011 m_ready  output  1  combinational; the response is accepted on any edge where m_valid && m_ready.
REQ-012 rf_we  output  1  registered register-file write enable.
REQ-013 rf_rd  output  5  registered register-file write index.
REQ-014 rf_data  output  32  registered register-file write data.
REQ-015 pend_valid  output  1  registered; the buffer holds an unwritten memory response.
REQ-016 pend_rd  output  5  registered; index held in the buffer, for the hazard scoreboard.

Function
REQ-017 The block SHALL share one register-file write port between the pipeline and a one-entry memory-response buffer (buf_full, buf_rd, buf_data).
REQ-018 Effective pipeline request SHALL be pv = p_valid && (p_rd != 0); rd 0 requests never stall and never write.
REQ-019 grant_buf SHALL be buf_full && (!pv || starve_cnt < STARVE_MAX); grant_p SHALL be pv && !grant_buf.
REQ-020 p_stall SHALL equal pv && grant_buf.
REQ-021 m_ready SHALL equal !buf_full || grant_buf, so the buffer drains and refills in the same cycle.
REQ-022 An accepted response with m_rd != 0 SHALL load the buffer; with m_rd == 0 it SHALL be consumed and the buffer left unchanged.
REQ-023 buf_full next SHALL be (buf_full && !grant_buf) || (accepted with m_rd != 0).
REQ-024 On grant_buf, the next edge SHALL write rf_we=1, rf_rd=buf_rd, rf_data=buf_data.
REQ-025 On grant_p, the next edge SHALL write rf_we=1, rf_rd=p_rd, rf_data=p_data.
REQ-026 With no grant, rf_we SHALL be 0 and rf_rd/rf_data SHALL hold their previous values.
REQ-027 Write latency SHALL be exactly one cycle from grant to rf_we.
REQ-028 starve_cnt (4 bits) SHALL increment on grant_buf && pv, clear on grant_p or !pv, and never exceed STARVE_MAX.
REQ-029 Once starve_cnt == STARVE_MAX with pv and buf_full, the pipeline SHALL win the next grant; the buffer waits and m_ready is 0.
REQ-030 pend_valid/pend_rd SHALL mirror buf_full/buf_rd after each edge.
REQ-031 Write ordering to the same rd is the scoreboard's responsibility; the block SHALL perform no same-rd merging or reordering checks.

Reset
REQ-032 While rst is high at an edge: rf_we=0, rf_rd=0, rf_data=0, buf_full=0, pend_valid=0, pend_rd=0, starve_cnt=0.
REQ-033 Reset asserted mid-operation SHALL discard any buffered response with no write.
REQ-034 While rst is high, m_ready SHALL be 1, p_stall SHALL be 0, and accepted inputs SHALL be dropped.

Verification
REQ-035 Pipeline only: p_valid=1, p_rd=5, p_data=0x1234 -> next cycle rf_we=1, rf_rd=5, rf_data=0x1234; p_stall=0.
REQ-036 Contention: buffer holds rd=7 data 0xAA and p_valid=1, rd=3 -> p_stall=1 -> next cycle writes rd 7 -> following cycle writes rd 3.
REQ-037 Starvation: STARVE_MAX=4, p_valid held, m_valid every cycle -> exactly 4 buffer writes, then 1 pipeline write with m_ready=0 that cycle; pattern repeats.
REQ-038 Drain plus refill: buffer full, p_valid=0, m_valid=1, rd=9 -> m_ready=1, previous entry written, buffer holds rd 9, pend_rd=9.
REQ-039 rd 0: m_rd=0 and p_rd=0 together -> both consumed, rf_we stays 0, pend_valid stays 0, p_stall=0.
REQ-040 Reset with buffer full (rd=12) -> pend_valid=0, no rf_we pulse for rd 12 after release.
